// File: rtl/sap_pkg.sv
// Shared definitions for the SAP core: opcode values, field widths and the
// sequencer state encoding used by both the controller and the datapath.
package sap_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_STA = 4'h3;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h4;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h5;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h6;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_RESET, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } seq_state_t;

  // T-state that executes on the coming edge, given the one that executed last.
  function automatic seq_state_t step_after(input seq_state_t s);
    case (s)
      ST_RESET, ST_T6: return ST_T1;
      ST_T1:           return ST_T2;
      ST_T2:           return ST_T3;
      ST_T3:           return ST_T4;
      ST_T4:           return ST_T5;
      ST_T5:           return ST_T6;
      default:         return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/sap_ctrl_seq.sv
// Six-step instruction sequencer: turns the current opcode, flags and T-state
// into one-edge control strobes for the SAP datapath.
module sap_ctrl_seq (
  input  logic       clk,
  input  logic       low_clr,
  input  logic [3:0] opcode_i,
  input  logic       carry_i,
  input  logic       zero_i,
  output logic       mar_from_pc_o,
  output logic       pc_inc_o,
  output logic       ir_load_o,
  output logic       mar_from_opd_o,
  output logic       acc_from_mem_o,
  output logic       b_load_o,
  output logic       alu_add_o,
  output logic       alu_sub_o,
  output logic       mem_we_o,
  output logic       pc_load_o,
  output logic       out_load_o,
  output logic       halted_o
);
  import sap_pkg::*;

  // state_q records the step executed at the last edge, so RESET is left on
  // the very first released edge while that edge already performs T1.
  seq_state_t state_q, state_d, exec_s;

  always_ff @(posedge clk) begin
    if (!low_clr) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    exec_s         = step_after(state_q);
    state_d        = exec_s;
    mar_from_pc_o  = 1'b0;
    pc_inc_o       = 1'b0;
    ir_load_o      = 1'b0;
    mar_from_opd_o = 1'b0;
    acc_from_mem_o = 1'b0;
    b_load_o       = 1'b0;
    alu_add_o      = 1'b0;
    alu_sub_o      = 1'b0;
    mem_we_o       = 1'b0;
    pc_load_o      = 1'b0;
    out_load_o     = 1'b0;
    case (exec_s)
      ST_T1: mar_from_pc_o = 1'b1;
      ST_T2: pc_inc_o      = 1'b1;
      ST_T3: ir_load_o     = 1'b1;
      ST_T4: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_from_opd_o = 1'b1;
          OP_JMP: pc_load_o  = 1'b1;
          OP_JZ:  pc_load_o  = zero_i;
          OP_JC:  pc_load_o  = carry_i;
          OP_OUT: out_load_o = 1'b1;
          OP_HLT: state_d    = ST_HALT;
          default: ;
        endcase
      end
      ST_T5: begin
        case (opcode_i)
          OP_LDA:         acc_from_mem_o = 1'b1;
          OP_ADD, OP_SUB: b_load_o       = 1'b1;
          OP_STA:         mem_we_o       = 1'b1;
          default: ;
        endcase
      end
      ST_T6: begin
        alu_add_o = (opcode_i == OP_ADD);
        alu_sub_o = (opcode_i == OP_SUB);
      end
      default: ;
    endcase
  end

  assign halted_o = (state_q == ST_HALT);

endmodule

// File: rtl/sap_core_param.sv
// Parameterised SAP-1 style accumulator machine: datapath registers, ALU and
// unified program/data memory, sequenced by sap_ctrl_seq.
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              low_clr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              halted,
  output logic [1:0]        flags,
  output logic [ADDR_W-1:0] pc_dbg
);
  import sap_pkg::*;

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d, ir_opd_q;
  logic [OPC_W-1:0]  ir_opc_q;
  logic [DATA_W-1:0] acc_q, b_q, out_q, b_opnd, mem_rd_q;
  logic [DATA_W:0]   alu_sum;
  logic              out_valid_q, carry_q, zero_q;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic mar_from_pc, pc_inc, ir_load, mar_from_opd, acc_from_mem, b_load;
  logic alu_add, alu_sub, mem_we, pc_load, out_load;

  sap_ctrl_seq u_ctrl (
    .clk            (clk),
    .low_clr        (low_clr),
    .opcode_i       (ir_opc_q),
    .carry_i        (carry_q),
    .zero_i         (zero_q),
    .mar_from_pc_o  (mar_from_pc),
    .pc_inc_o       (pc_inc),
    .ir_load_o      (ir_load),
    .mar_from_opd_o (mar_from_opd),
    .acc_from_mem_o (acc_from_mem),
    .b_load_o       (b_load),
    .alu_add_o      (alu_add),
    .alu_sub_o      (alu_sub),
    .mem_we_o       (mem_we),
    .pc_load_o      (pc_load),
    .out_load_o     (out_load),
    .halted_o       (halted)
  );

  always_comb begin
    mar_d = mar_q;
    if (mar_from_pc)       mar_d = pc_q;
    else if (mar_from_opd) mar_d = ir_opd_q;
    pc_d = pc_q;
    if (pc_inc)       pc_d = pc_q + ADDR_W'(1);
    else if (pc_load) pc_d = ir_opd_q;
  end

  // Subtraction is ACC + ~B + 1, so the carry out doubles as "no borrow".
  assign b_opnd  = alu_sub ? ~b_q : b_q;
  assign alu_sum = {1'b0, acc_q} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, alu_sub};

  // Read address follows next-state MAR so the registered read is ready one
  // step after MAR is loaded (T1->T3 fetch, T4->T5 operand).
  always_ff @(posedge clk) begin
    if (!low_clr) begin
      if (prog_we) mem_q[prog_addr] <= prog_data;
    end else if (mem_we) begin
      mem_q[mar_q] <= acc_q;
    end
    mem_rd_q <= mem_q[mar_d];
  end

  always_ff @(posedge clk) begin
    if (!low_clr) begin
      pc_q        <= '0;
      mar_q       <= '0;
      ir_opc_q    <= '0;
      ir_opd_q    <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      out_valid_q <= out_load;
      if (ir_load) begin
        ir_opc_q <= mem_rd_q[DATA_W-1 -: OPC_W];
        ir_opd_q <= mem_rd_q[ADDR_W-1:0];
      end
      if (acc_from_mem)          acc_q <= mem_rd_q;
      else if (alu_add | alu_sub) acc_q <= alu_sum[DATA_W-1:0];
      if (b_load) b_q <= mem_rd_q;
      if (alu_add | alu_sub) begin
        carry_q <= alu_sum[DATA_W];
        zero_q  <= (alu_sum[DATA_W-1:0] == '0);
      end
      if (out_load) out_q <= acc_q;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign flags     = {carry_q, zero_q};
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_sap_core_param.sv
// Bench for sap_core_param: directed programs plus random programs checked
// against an instruction-level model, OUT results matched through a scoreboard.
module tb_sap_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        lc8, we8, ov8, h8;
  logic [3:0]  pa8, pc8;
  logic [7:0]  pd8, out8;
  logic [1:0]  fl8;
  logic        lc12, we12, ov12, h12;
  logic [7:0]  pa12, pc12;
  logic [11:0] pd12, out12;
  logic [1:0]  fl12;

  sap_core_param dut8 (
    .clk(clk), .low_clr(lc8), .prog_we(we8), .prog_addr(pa8), .prog_data(pd8),
    .out(out8), .out_valid(ov8), .halted(h8), .flags(fl8), .pc_dbg(pc8)
  );

  sap_core_param #(.DATA_W(12), .ADDR_W(8)) dut12 (
    .clk(clk), .low_clr(lc12), .prog_we(we12), .prog_addr(pa12), .prog_data(pd12),
    .out(out12), .out_valid(ov12), .halted(h12), .flags(fl12), .pc_dbg(pc12)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int val; int edge_no; } exp_t;
  exp_t q8[$];
  exp_t q12[$];
  exp_t e8, e12;

  // Rising edges seen since reset was released.
  int ec8 = 0, ec12 = 0;
  always @(posedge clk) begin
    ec8  <= lc8  ? ec8 + 1  : 0;
    ec12 <= lc12 ? ec12 + 1 : 0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ov8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL out8_unexpected: got 0x%0h at edge %0d, expected no output", out8, ec8);
      end else begin
        e8 = q8.pop_front();
        if (int'(out8) != e8.val || ec8 != e8.edge_no) begin
          errors++;
          $display("FAIL out8: got 0x%0h at edge %0d, expected 0x%0h at edge %0d",
                   out8, ec8, e8.val, e8.edge_no);
        end
      end
    end
    if (ov12) begin
      checks++;
      if (q12.size() == 0) begin
        errors++;
        $display("FAIL out12_unexpected: got 0x%0h at edge %0d, expected no output", out12, ec12);
      end else begin
        e12 = q12.pop_front();
        if (int'(out12) != e12.val || ec12 != e12.edge_no) begin
          errors++;
          $display("FAIL out12: got 0x%0h at edge %0d, expected 0x%0h at edge %0d",
                   out12, ec12, e12.val, e12.edge_no);
        end
      end
    end
  end

  function automatic int d_out(input int sel); return sel ? int'(out12) : int'(out8); endfunction
  function automatic int d_ov (input int sel); return sel ? int'(ov12)  : int'(ov8);  endfunction
  function automatic int d_h  (input int sel); return sel ? int'(h12)   : int'(h8);   endfunction
  function automatic int d_fl (input int sel); return sel ? int'(fl12)  : int'(fl8);  endfunction
  function automatic int d_pc (input int sel); return sel ? int'(pc12)  : int'(pc8);  endfunction
  function automatic int q_sz (input int sel); return sel ? q12.size()  : q8.size();  endfunction

  // Instruction-level reference: memory image persists across resets like the DUT's.
  int mmem [2][256];
  int m_pc, m_carry, m_zero, m_halt, m_halt_edge, m_out;

  task automatic run_model(input int sel, input int n_instr);
    int dw, depth, mask, acc, word, op, opd, b;
    exp_t e;
    dw = sel ? 12 : 8;
    depth = sel ? 256 : 16;
    mask = (1 << dw) - 1;
    acc = 0;
    m_pc = 0; m_carry = 0; m_zero = 0; m_halt = 0; m_halt_edge = 0; m_out = 0;
    for (int k = 0; k < n_instr && m_halt == 0; k++) begin
      word = mmem[sel][m_pc];
      op   = word >> (dw - 4);
      opd  = word % depth;
      m_pc = (m_pc + 1) % depth;
      b    = mmem[sel][opd];
      case (op)
        0: acc = b;
        1: begin m_carry = (acc + b > mask) ? 1 : 0; acc = (acc + b) & mask; m_zero = (acc == 0) ? 1 : 0; end
        2: begin m_carry = (acc >= b) ? 1 : 0; acc = (acc - b) & mask; m_zero = (acc == 0) ? 1 : 0; end
        3: mmem[sel][opd] = acc;
        4: m_pc = opd;
        5: if (m_zero != 0) m_pc = opd;
        6: if (m_carry != 0) m_pc = opd;
        14: begin
          m_out = acc;
          e.val = acc;
          e.edge_no = 6 * k + 4;
          if (sel != 0) q12.push_back(e); else q8.push_back(e);
        end
        15: begin m_halt = 1; m_halt_edge = 6 * k + 4; end
        default: ;
      endcase
    end
  endtask

  int ld_a[$], ld_d[$];
  task automatic add_ld(input int a, input int d);
    ld_a.push_back(a);
    ld_d.push_back(d);
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset (checking the cleared state), load queued words, then release reset.
  task automatic load_and_reset(input int sel);
    @(negedge clk);
    if (sel != 0) lc12 = 1'b0; else lc8 = 1'b0;
    @(negedge clk);
    chk("rst_pc",     d_pc(sel),  0);
    chk("rst_flags",  d_fl(sel),  0);
    chk("rst_out",    d_out(sel), 0);
    chk("rst_valid",  d_ov(sel),  0);
    chk("rst_halted", d_h(sel),   0);
    for (int i = 0; i < ld_a.size(); i++) begin
      if (sel != 0) begin we12 = 1'b1; pa12 = 8'(ld_a[i]); pd12 = 12'(ld_d[i]); end
      else          begin we8  = 1'b1; pa8  = 4'(ld_a[i]); pd8  = 8'(ld_d[i]);  end
      mmem[sel][ld_a[i]] = ld_d[i];
      @(negedge clk);
    end
    we8 = 1'b0; we12 = 1'b0;
    if (sel != 0) lc12 = 1'b1; else lc8 = 1'b1;
    ld_a.delete();
    ld_d.delete();
  endtask

  task automatic run_checked(input int sel, input int k, input string tag);
    run_model(sel, k);
    if (m_halt != 0) begin
      run_edges(m_halt_edge - 1);
      chk("halted_early", d_h(sel), 0);
      run_edges(1);
      chk("halted_set", d_h(sel), 1);
      run_edges(6);
    end else begin
      run_edges(6 * k);
    end
    chk("end_pc",     d_pc(sel),  m_pc);
    chk("end_flags",  d_fl(sel),  m_carry * 2 + m_zero);
    chk("end_halted", d_h(sel),   m_halt);
    chk("end_out",    d_out(sel), m_out);
    chk("sb_drained", q_sz(sel),  0);
    $display("run %s dut%0d: pc=0x%0h flags=%0d halted=%0d out=0x%0h",
             tag, sel ? 12 : 8, d_pc(sel), d_fl(sel), d_h(sel), d_out(sel));
  endtask

  task automatic load_fig1();
    add_ld(0, 'h09); add_ld(1, 'h1A); add_ld(2, 'hE0); add_ld(3, 'hF0);
    add_ld(9, 'h10); add_ld(10, 'h14);
  endtask

  task automatic load_jc();
    add_ld(0, 'h09); add_ld(1, 'h1A); add_ld(2, 'h68); add_ld(3, 'hF0);
    add_ld(8, 'hE0); add_ld(9, 'hFF); add_ld(10, 'h01);
  endtask

  initial begin
    lc8 = 1'b0; we8 = 1'b0; pa8 = '0; pd8 = '0;
    lc12 = 1'b0; we12 = 1'b0; pa12 = '0; pd12 = '0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 256; a++) mmem[s][a] = 0;

    // LDA/ADD/OUT/HLT: 0x10+0x14 shown at edge 16, halt at edge 22.
    load_fig1();
    load_and_reset(0);
    run_checked(0, 8, "fig1");
    chk("fig1_out", int'(out8), 'h24);

    // SUB equal operands, then SUB with borrow.
    add_ld(0, 'h09); add_ld(1, 'h2A); add_ld(2, 'hE0); add_ld(3, 'hF0);
    add_ld(9, 'h05); add_ld(10, 'h05);
    load_and_reset(0);
    run_checked(0, 8, "sub_eq");
    chk("sub_eq_flags", int'(fl8), 3);
    add_ld(9, 'h03);
    load_and_reset(0);
    run_checked(0, 8, "sub_borrow");
    chk("sub_borrow_out", int'(out8), 'hFE);
    chk("sub_borrow_flags", int'(fl8), 0);

    // ADD overflow to zero, JC taken; then run on through OUT at 8 and HLT data word.
    load_jc();
    load_and_reset(0);
    run_checked(0, 3, "jc");
    chk("jc_pc", int'(pc8), 8);
    chk("jc_flags", int'(fl8), 3);
    load_and_reset(0);
    run_checked(0, 8, "jc_full");

    // JZ not taken with zero=0 leaves PC at the fall-through address.
    add_ld(2, 'h58); add_ld(9, 'h01); add_ld(10, 'h01);
    load_and_reset(0);
    run_checked(0, 3, "jz_not");
    chk("jz_not_pc", int'(pc8), 3);

    // STA then LDA back; memory survives a reset that reloads only the code.
    add_ld(0, 'h0D); add_ld(1, 'h3C); add_ld(2, 'h0C); add_ld(3, 'hE0); add_ld(4, 'hF0);
    add_ld(12, 'h00); add_ld(13, 'h5A);
    load_and_reset(0);
    run_checked(0, 8, "sta_lda");
    chk("sta_lda_out", int'(out8), 'h5A);
    add_ld(0, 'h0C); add_ld(1, 'hE0); add_ld(2, 'hF0);
    load_and_reset(0);
    run_checked(0, 8, "sta_keep");
    chk("sta_keep_out", int'(out8), 'h5A);

    // All-NOP program: address 0xF is instruction 15, whose T2 is edge 6*15+2.
    for (int a = 0; a < 16; a++) add_ld(a, 'h70);
    load_and_reset(0);
    run_edges(91);
    chk("wrap_pc_before", int'(pc8), 15);
    run_edges(1);
    chk("wrap_pc_after", int'(pc8), 0);
    $display("run nop_wrap dut8: pc=0x%0h", pc8);

    // Reset landing on T5 (edge 17) of the JC instruction.
    load_jc();
    load_and_reset(0);
    run_model(0, 0);
    run_edges(16);
    chk("t5_pre_pc", int'(pc8), 8);
    lc8 = 1'b0;
    @(negedge clk);
    chk("t5_rst_pc", int'(pc8), 0);
    chk("t5_rst_flags", int'(fl8), 0);
    chk("t5_rst_halted", int'(h8), 0);
    $display("run t5_reset dut8: pc=0x%0h flags=%0d", pc8, fl8);

    // Reset on T5 of OUT clears out and out_valid; reset in HALT clears halted.
    load_fig1();
    load_and_reset(0);
    q8.push_back('{'h24, 16});
    run_edges(16);
    chk("out_pre_rst", int'(out8), 'h24);
    lc8 = 1'b0;
    @(negedge clk);
    chk("out_rst_out", int'(out8), 0);
    chk("out_rst_valid", int'(ov8), 0);
    load_and_reset(0);
    q8.push_back('{'h24, 16});
    run_edges(25);
    chk("halt_pre_rst", int'(h8), 1);
    lc8 = 1'b0;
    @(negedge clk);
    chk("halt_rst", int'(h8), 0);
    chk("halt_rst_pc", int'(pc8), 0);
    $display("run halt_reset dut8: halted=%0d pc=0x%0h", h8, pc8);

    // Random programs on the default configuration.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 16; a++) add_ld(a, int'($urandom_range(0, 255)));
      load_and_reset(0);
      run_checked(0, 12, "rand8");
    end
    lc8 = 1'b0;

    // Wide configuration: same program with 12-bit words and 8-bit operands.
    add_ld(0, 'h009); add_ld(1, 'h10A); add_ld(2, 'hE00); add_ld(3, 'hF00);
    add_ld(9, 'h010); add_ld(10, 'h014);
    load_and_reset(1);
    run_checked(1, 8, "fig1_w");
    chk("fig1_w_out", int'(out12), 'h24);
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 256; a++) add_ld(a, int'($urandom_range(0, 4095)));
      load_and_reset(1);
      run_checked(1, 12, "rand12");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
